regfile_arbiter: RTL

Two-requester arbiter and access sequencer for the 4-entry × 16-bit register file. It shares the file's two read ports and single write port between the core datapath (requester 0) and the debug/scan port (requester 1). Each granted request becomes one 3-cycle transaction on the register-file pins. The block sits between the requesters and `registerFile`; requesters never drive the file directly.

---
 rtl/regfile_arbiter_pkg.sv | 22 ++
 rtl/regfile_arbiter_if.sv | 37 +++
 rtl/regfile_arbiter_rr_arbiter2.sv | 13 +
 rtl/regfile_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared constants and types for the register-file arbiter: data width,
// FSM encodings and requester identifiers.
package regfile_arbiter_pkg;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_W    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  // One-hot requester mask used for the per-requester strobes.
  function automatic logic [1:0] req_onehot(input logic id);
    return (id == REQ_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side bundle of the register-file arbiter: request fields from
// both requesters plus the accept strobe and the shared response.
interface regfile_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 2
);

  logic [1:0]           req_valid;
  logic [1:0]           req_write;
  logic [ADDR_W-1:0]    req0_r1;
  logic [ADDR_W-1:0]    req0_r2;
  logic [ADDR_W-1:0]    req0_rd;
  logic [ADDR_W-1:0]    req1_r1;
  logic [ADDR_W-1:0]    req1_r2;
  logic [ADDR_W-1:0]    req1_rd;
  logic [WORD_SIZE-1:0] req0_wdata;
  logic [WORD_SIZE-1:0] req1_wdata;
  logic [1:0]           req_ready;
  logic [1:0]           rsp_valid;
  logic [WORD_SIZE-1:0] rsp_data1;
  logic [WORD_SIZE-1:0] rsp_data2;

  modport master (
    output req_valid, req_write,
    output req0_r1, req0_r2, req0_rd, req0_wdata,
    output req1_r1, req1_r2, req1_rd, req1_wdata,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2
  );

  modport slave (
    input  req_valid, req_write,
    input  req0_r1, req0_r2, req0_rd, req0_wdata,
    input  req1_r1, req1_r2, req1_rd, req1_wdata,
    output req_ready, rsp_valid, rsp_data1, rsp_data2
  );

endinterface

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin selector: a lone requester wins, and on a
// tie the requester that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       any
);

  assign any = |req;
  assign sel = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the 4x16 register file between the core and debug requesters; each
// grant becomes an IDLE -> ACCESS -> RESP sequence on the file pins.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = regfile_arbiter_pkg::WORD_SIZE,
  parameter int ADDR_W    = regfile_arbiter_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0]    rf_r1,
  output logic [ADDR_W-1:0]    rf_r2,
  output logic [ADDR_W-1:0]    rf_rd,
  output logic [WORD_SIZE-1:0] rf_writeData,
  output logic                 rf_regWrite,
  input  logic [WORD_SIZE-1:0] rf_readData1,
  input  logic [WORD_SIZE-1:0] rf_readData2
);

  state_t               state;
  logic                 last_grant;
  logic                 sel;
  logic                 any;
  logic                 accept;

  logic                 txn_owner;
  logic                 txn_write;
  logic [ADDR_W-1:0]    txn_r1;
  logic [ADDR_W-1:0]    txn_r2;
  logic [ADDR_W-1:0]    txn_rd;
  logic [WORD_SIZE-1:0] txn_wdata;

  rr_arbiter2 u_arb (
    .req  (bus.req_valid),
    .last (last_grant),
    .sel  (sel),
    .any  (any)
  );

  // Accept is only offered in IDLE and is suppressed while reset is held.
  always_comb begin
    bus.req_ready = 2'b00;
    if (reset_n && (state == IDLE) && any)
      bus.req_ready = req_onehot(sel);
  end

  assign accept = |bus.req_ready;

  // Stage boundary: accept edge latches the winner's fields.
  always_ff @(posedge clk) begin
    if (accept) begin
      txn_owner <= sel;
      txn_write <= bus.req_write[sel];
      if (sel == REQ_DBG) begin
        txn_r1    <= bus.req1_r1;
        txn_r2    <= bus.req1_r2;
        txn_rd    <= bus.req1_rd;
        txn_wdata <= bus.req1_wdata;
      end else begin
        txn_r1    <= bus.req0_r1;
        txn_r2    <= bus.req0_r2;
        txn_rd    <= bus.req0_rd;
        txn_wdata <= bus.req0_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= REQ_DBG;
      bus.rsp_valid <= 2'b00;
      bus.rsp_data1 <= '0;
      bus.rsp_data2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.rsp_valid <= 2'b00;
          if (accept) begin
            last_grant <= sel;
            state      <= ACCESS;
          end
        end
        // Stage boundary: read data sampled as the write commits.
        ACCESS: begin
          bus.rsp_data1 <= txn_write ? '0 : rf_readData1;
          bus.rsp_data2 <= txn_write ? '0 : rf_readData2;
          bus.rsp_valid <= req_onehot(txn_owner);
          state         <= RESP;
        end
        RESP: begin
          bus.rsp_valid <= 2'b00;
          state         <= IDLE;
        end
        default: begin
          bus.rsp_valid <= 2'b00;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Register-file pins are only live during ACCESS; zero otherwise.
  always_comb begin
    rf_r1        = '0;
    rf_r2        = '0;
    rf_rd        = '0;
    rf_writeData = '0;
    rf_regWrite  = 1'b0;
    if (state == ACCESS) begin
      rf_r1        = txn_r1;
      rf_r2        = txn_r2;
      rf_rd        = txn_rd;
      rf_writeData = txn_wdata;
      rf_regWrite  = txn_write;
    end
  end

endmodule
